// File: rtl/mem_interface_if.sv
// Memory-side request/response bundle between the MAR/MDR controller and a word RAM.
// The master drives the request; the slave answers with rdata and a (possibly combinational) ack.
interface mem_interface_if #(
    parameter int ADDR_W = 9
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_interface.sv
// MAR/MDR memory interface: one RAM access per Read/Write strobe; Done pulses for one cycle at the end.
// Latency: strobe sampled at edge k, Done high k+1..k+2 with a same-cycle ack; request held until ack.
// Backpressure: mem_ack stalls the FSM; optional MEM_TIMEOUT_EN aborts after TIMEOUT request cycles.
module mem_interface #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [31:0]       MDR_q,
    output logic [ADDR_W-1:0] MAR_q,
    mem_interface_if.master   mem,
    output logic              Busy,
    output logic              Done,
    output logic              BusErr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_REQ   = 2'd1,
        WR_REQ   = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t state;
    logic   armed;
    logic   req_q;
    logic   we_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             bus_err_q;
    assign BusErr = bus_err_q;
`else
    assign BusErr = 1'b0;
    wire unused_timeout = (TIMEOUT > 0);
`endif

    wire unused_bus_hi = ^BusMuxOut[31:ADDR_W];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            armed <= 1'b1;
            req_q <= 1'b0;
            we_q  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            MAR_q <= '0;
            MDR_q <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt   <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            // Re-arm only once both strobes are released, so a held strobe gives one access.
            if (!Read && !Write) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (MARin) MAR_q <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin && !Read) MDR_q <= BusMuxOut;
                    if (armed && (Read || Write)) begin
                        state <= Read ? RD_REQ : WR_REQ;
                        req_q <= 1'b1;
                        we_q  <= !Read;
                        Busy  <= 1'b1;
                        armed <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                RD_REQ, WR_REQ: begin
                    if (mem.mem_ack) begin
                        if (state == RD_REQ) MDR_q <= mem.mem_rdata;
                        state <= COMPLETE;
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        Done  <= 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= COMPLETE;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        Done      <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                COMPLETE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = req_q ? MAR_q : '0;
    assign mem.mem_wdata = req_q ? MDR_q : '0;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: directed scenarios with literal expectations plus a randomized run
// checked every cycle against an access-level reference model.
module tb_mem_interface;
    localparam int AW = 9;
    localparam int TO = 16;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [31:0]   BusMuxOut = '0;
    logic          MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
    logic [31:0]   MDR_q;
    logic [AW-1:0] MAR_q;
    logic          Busy, Done, BusErr;

    mem_interface_if #(.ADDR_W(AW)) mem_if ();

    mem_interface #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut),
        .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
        .MDR_q(MDR_q), .MAR_q(MAR_q), .mem(mem_if.master),
        .Busy(Busy), .Done(Done), .BusErr(BusErr)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    // Reference model: access phase 0=idle 1=read pending 2=write pending 3=finished.
    int          m_phase;
    logic [AW-1:0] m_mar;
    logic [31:0] m_mdr;
    logic        m_armed, m_err;
    int          m_reqcyc;

    // Memory responder behaviour.
    int          ack_wait = 0;
    logic [31:0] rdata_val = '0;

    // DUT observations for directed scenarios.
    int n_req, n_done, n_we, n_match;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_mar = '0; m_mdr = '0; m_armed = 1'b1; m_err = 1'b0; m_reqcyc = 0;
    endtask

    task automatic model_edge(input logic ack, input logic [31:0] rdata);
        int nxt;
        nxt = m_phase;
        if (m_phase == 0) begin
            if (MARin) m_mar = BusMuxOut[AW-1:0];
            if (MDRin && !Read) m_mdr = BusMuxOut;
            if (m_armed && Read) nxt = 1;
            else if (m_armed && Write) nxt = 2;
            if (nxt != 0) begin m_armed = 1'b0; m_reqcyc = 0; end
        end else if (m_phase == 1 || m_phase == 2) begin
            if (ack) begin
                if (m_phase == 1) m_mdr = rdata;
                nxt = 3;
            end else begin
                m_reqcyc++;
`ifdef MEM_TIMEOUT_EN
                if (m_reqcyc == TO) begin nxt = 3; m_err = 1'b1; end
`endif
            end
        end else begin
            nxt = 0;
        end
        if (!Read && !Write) m_armed = 1'b1;
        m_phase = nxt;
    endtask

    task automatic check_all();
        logic e_req;
        e_req = (m_phase == 1 || m_phase == 2);
        chk("MAR_q", 32'(MAR_q), 32'(m_mar));
        chk("MDR_q", MDR_q, m_mdr);
        chk("mem_req", 32'(mem_if.mem_req), 32'(e_req));
        chk("mem_we", 32'(mem_if.mem_we), 32'(m_phase == 2));
        chk("mem_addr", 32'(mem_if.mem_addr), e_req ? 32'(m_mar) : 32'd0);
        chk("mem_wdata", mem_if.mem_wdata, e_req ? m_mdr : 32'd0);
        chk("Busy", 32'(Busy), 32'(m_phase != 0));
        chk("Done", 32'(Done), 32'(m_phase == 3));
        chk("BusErr", 32'(BusErr), 32'(m_err));
        n_req  += int'(mem_if.mem_req);
        n_done += int'(Done);
        n_we   += int'(mem_if.mem_we);
        if (mem_if.mem_we && mem_if.mem_addr == 9'h1FF && mem_if.mem_wdata == 32'h12345678) n_match++;
    endtask

    // Called at a falling edge with inputs already set; ends at the next falling edge.
    task automatic step();
        logic ack;
        ack = (m_phase == 1 || m_phase == 2) && (m_reqcyc >= ack_wait);
        mem_if.mem_ack   = ack;
        mem_if.mem_rdata = rdata_val;
        @(posedge Clock);
        model_edge(ack, rdata_val);
        @(negedge Clock);
        check_all();
    endtask

    task automatic clear_obs();
        n_req = 0; n_done = 0; n_we = 0; n_match = 0;
    endtask

    task automatic idle_inputs();
        MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; starts and ends at a falling edge.
    task automatic do_reset();
        #2;
        Reset = 1'b0;
        mem_if.mem_ack = 1'b0;
        model_reset();
        #1;
        chk("rst mem_req", 32'(mem_if.mem_req), 32'd0);
        chk("rst MDR_q", MDR_q, 32'd0);
        chk("rst MAR_q", 32'(MAR_q), 32'd0);
        chk("rst Busy", 32'(Busy), 32'd0);
        chk("rst Done", 32'(Done), 32'd0);
        chk("rst BusErr", 32'(BusErr), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = '0;
        model_reset();
        clear_obs();
        @(negedge Clock);
        @(negedge Clock);
        do_reset();

        // Held Read: exactly one access with a same-cycle ack.
        BusMuxOut = 32'h5; MARin = 1'b1; step(); idle_inputs();
        clear_obs(); ack_wait = 0; rdata_val = 32'hDEADBEEF;
        Read = 1'b1;
        for (int i = 0; i < 4; i++) step();
        Read = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("rd req cycles", n_req, 1);
        chk("rd done count", n_done, 1);
        chk("rd MDR_q", MDR_q, 32'hDEADBEEF);

        // Write with three wait cycles before ack.
        BusMuxOut = 32'h12345678; MDRin = 1'b1; step(); idle_inputs();
        BusMuxOut = 32'h1FF; MARin = 1'b1; step(); idle_inputs();
        clear_obs(); ack_wait = 3;
        Write = 1'b1; step(); Write = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("wr stable cycles", n_match, 4);
        chk("wr done count", n_done, 1);

        // Read and Write together: read wins.
        clear_obs(); ack_wait = 0; rdata_val = 32'h0BADF00D;
        Read = 1'b1; Write = 1'b1; step(); idle_inputs();
        for (int i = 0; i < 3; i++) step();
        chk("rw we cycles", n_we, 0);
        chk("rw req cycles", n_req, 1);
        chk("rw MDR_q", MDR_q, 32'h0BADF00D);

        // MARin while busy is ignored.
        ack_wait = 5;
        Read = 1'b1; step(); Read = 1'b0;
        BusMuxOut = 32'h0AA; MARin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("busy MAR_q", 32'(MAR_q), 32'h1FF);
            chk("busy mem_addr", 32'(mem_if.mem_addr), 32'h1FF);
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) step();

        // Reset in the middle of a read: no Done, MDR cleared.
        clear_obs(); ack_wait = 1000;
        Read = 1'b1; step(); Read = 1'b0; step();
        do_reset();
        step();
        chk("abort done count", n_done, 0);

        // Never-acked access.
        BusMuxOut = 32'hCAFEF00D; MDRin = 1'b1; step(); idle_inputs();
        clear_obs(); ack_wait = 1000;
        Read = 1'b1; step(); Read = 1'b0;
        for (int i = 0; i < 30; i++) step();
`ifdef MEM_TIMEOUT_EN
        chk("tmo req cycles", n_req, TO);
        chk("tmo done count", n_done, 1);
        chk("tmo BusErr", 32'(BusErr), 32'd1);
        chk("tmo MDR_q", MDR_q, 32'hCAFEF00D);
`else
        chk("hold req cycles", n_req, 31);
        chk("hold done count", n_done, 0);
        chk("hold BusErr", 32'(BusErr), 32'd0);
`endif
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            Read      = ($urandom_range(0, 3) == 0);
            Write     = ($urandom_range(0, 3) == 0);
            MARin     = $urandom_range(0, 1);
            MDRin     = $urandom_range(0, 1);
            BusMuxOut = $urandom;
            rdata_val = $urandom;
            if (m_phase == 0) ack_wait = $urandom_range(0, 4);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
